// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller with parity, framing, overrun and break handling
//
// Purpose: receives asynchronous serial frames (start, 6..DW data bits LSB-first,
//   optional parity, one or two stop bits) and presents the word with status flags
//   until the host reads it.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst      - synchronous active-high reset
//   rx       - asynchronous serial line, idles high
//   k        - clocks per bit time (values below 2 are treated as 2)
//   nbits    - data-bit count: 0=DW-2, 1=DW-1, 2/3=DW
//   p_en     - a parity bit follows the data bits
//   p_odd    - 1=odd parity, 0=even parity
//   two_stop - two stop bits expected
//   rd       - host read strobe, clears rdy and the error flags
//   data     - received word, LSB-aligned, unused MSBs zero
//   rdy      - word valid
//   perr     - parity error of the word in data
//   ferr     - framing error of the word in data
//   ovf      - a completed word overwrote an unread one
//   busy     - receiver is inside a frame (not IDLE)

module uart_rx_ctrl #(
  parameter int K_W = 19,
  parameter int DW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  input  logic [K_W-1:0] k,
  input  logic [1:0]     nbits,
  input  logic           p_en,
  input  logic           p_odd,
  input  logic           two_stop,
  input  logic           rd,
  output logic [DW-1:0]  data,
  output logic           rdy,
  output logic           perr,
  output logic           ferr,
  output logic           ovf,
  output logic           busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  // Bit index / bit count width; DW is at most 9.
  localparam int BW = 4;

  logic           rx_meta;
  logic           rxs;
  logic           rxs_d;
  logic [2:0]     state;
  logic [K_W-1:0] cnt;
  logic [K_W-1:0] k_c;
  logic [BW-1:0]  nb_c;
  logic           p_en_c;
  logic           p_odd_c;
  logic           two_c;
  logic [BW-1:0]  bit_idx;
  logic [DW-1:0]  shreg;
  logic           par_acc;
  logic           perr_pend;
  logic           ferr_pend;
  logic           brk;

  logic [K_W-1:0] k_eff;
  logic [BW-1:0]  nb_eff;
  logic           hit;
  logic           sample_en;
  logic           vote;
  logic           start_det;
  logic           complete;
  logic           ferr_next;

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d2;
  // The vote window is centred one clock before the decision cycle so that
  // every state transition, and therefore rdy, lands on the same clock as in
  // the single-sample build.
  assign vote = (rxs_d2 & rxs_d) | (rxs_d & rxs) | (rxs_d2 & rxs);
`else
  assign vote = rxs;
`endif

  assign k_eff = (k < K_W'(2)) ? K_W'(2) : k;

  always_comb begin
    nb_eff = BW'(DW);
    case (nbits)
      2'd0:    nb_eff = BW'(DW - 2);
      2'd1:    nb_eff = BW'(DW - 1);
      default: nb_eff = BW'(DW);
    endcase
  end

  // cnt counts clocks since the rxs falling edge (detection cycle is count 0),
  // so the start bit is checked at k>>1 and every later bit k clocks on.
  assign hit       = (state == S_START) ? (cnt == (k_c >> 1)) : (cnt == (k_c - K_W'(1)));
  assign sample_en = (state != S_IDLE) && hit;
  assign start_det = (state == S_IDLE) && !brk && rxs_d && !rxs;
  assign ferr_next = ferr_pend | ~vote;
  assign complete  = sample_en &&
                     (((state == S_STOP1) && !two_c) || (state == S_STOP2));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      rxs_d     <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rxs_d2    <= 1'b1;
`endif
      state     <= S_IDLE;
      cnt       <= '0;
      k_c       <= K_W'(2);
      nb_c      <= '0;
      p_en_c    <= 1'b0;
      p_odd_c   <= 1'b0;
      two_c     <= 1'b0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      perr_pend <= 1'b0;
      ferr_pend <= 1'b0;
      brk       <= 1'b0;
      data      <= '0;
      rdy       <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
`ifdef UART_RX_MAJORITY_EN
      rxs_d2  <= rxs_d;
`endif

      // Bit-time counter: cleared on every sample, saturates instead of wrapping.
      if (state == S_IDLE) begin
        cnt <= start_det ? K_W'(1) : '0;
      end else if (sample_en) begin
        cnt <= '0;
      end else if (cnt != {K_W{1'b1}}) begin
        cnt <= cnt + K_W'(1);
      end

      case (state)
        S_IDLE: begin
          // A frame that ended in a framing error leaves the line low (break);
          // wait for the line to recover before arming start detection.
          if (brk && rxs) begin
            brk <= 1'b0;
          end
          if (start_det) begin
            state     <= S_START;
            k_c       <= k_eff;
            nb_c      <= nb_eff;
            p_en_c    <= p_en;
            p_odd_c   <= p_odd;
            two_c     <= two_stop;
            bit_idx   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            perr_pend <= 1'b0;
            ferr_pend <= 1'b0;
          end
        end

        S_START: begin
          if (sample_en) begin
            state   <= vote ? S_IDLE : S_DATA;
            bit_idx <= '0;
          end
        end

        S_DATA: begin
          if (sample_en) begin
            for (int i = 0; i < DW; i++) begin
              if (bit_idx == BW'(i)) begin
                shreg[i] <= vote;
              end
            end
            par_acc <= par_acc ^ vote;
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == (nb_c - BW'(1))) begin
              state <= p_en_c ? S_PARITY : S_STOP1;
            end
          end
        end

        S_PARITY: begin
          if (sample_en) begin
            perr_pend <= par_acc ^ vote ^ p_odd_c;
            state     <= S_STOP1;
          end
        end

        S_STOP1: begin
          if (sample_en) begin
            ferr_pend <= ferr_next;
            state     <= two_c ? S_STOP2 : S_IDLE;
          end
        end

        S_STOP2: begin
          if (sample_en) begin
            ferr_pend <= ferr_next;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase

      if (complete) begin
        brk <= ferr_next;
      end

      // Completion wins over a simultaneous read: the new word is fresh,
      // so it is not an overrun.
      if (complete) begin
        data <= shreg;
        rdy  <= 1'b1;
        perr <= perr_pend;
        ferr <= ferr_next;
        ovf  <= rdy & ~rd;
      end else if (rd) begin
        rdy  <= 1'b0;
        perr <= 1'b0;
        ferr <= 1'b0;
        ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL provide parameter K_W, default 19: width of the bit-time divisor input k.
REQ-002 SHALL provide parameter DW, default 8: width of the data output; legal values 7..9.
REQ-003 SHALL provide port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL provide port rx, input, 1: asynchronous serial line; idles high.
REQ-006 SHALL provide port k, input, K_W: clocks per bit time.
REQ-007 SHALL provide port nbits, input, 2: data-bit count, where 0=DW-2, 1=DW-1, 2=DW and 3=DW.
REQ-008 SHALL provide port p_en, input, 1: a parity bit follows the data bits.
REQ-009 SHALL provide port p_odd, input, 1: 1=odd parity, 0=even parity.
REQ-010 SHALL provide port two_stop, input, 1: two stop bits are expected.
REQ-011 SHALL provide port rd, input, 1: host read strobe that clears rdy and the error flags.
REQ-012 SHALL provide port data, output, DW: received word, LSB-aligned, with unused MSBs set to 0.
REQ-013 SHALL provide ports rdy, perr, ferr and ovf, each output, 1: word valid, parity error, framing error and overrun.
REQ-014 SHALL provide port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer and sample only the synchronized value (rxs); all latencies below are measured from rxs.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-017 SHALL, in IDLE, detect a 1->0 transition on rxs, enter START and capture k, nbits, p_en, p_odd and two_stop; later input changes have no effect on the frame in progress.
REQ-018 SHALL treat a captured k below 2 as 2.
REQ-019 SHALL, in START, sample rxs at count k>>1; a sample of 1 is a false start and returns to IDLE with no flag change; a sample of 0 enters DATA.
REQ-020 SHALL sample every later bit exactly k clocks after the previous sample, i.e. at mid-bit.
REQ-021 SHALL shift the DATA samples in LSB-first; after the configured bit count go to PARITY if p_en is set, else to STOP1.
REQ-022 SHALL, in PARITY, flag perr_pend when the XOR of the data bits, the parity bit and p_odd is 1.
REQ-023 SHALL, in STOP1, flag ferr_pend when the sample is 0; then go to STOP2 if two_stop is set, else complete the frame.
REQ-024 SHALL, in STOP2, sample and check the second stop bit the same way as STOP1, then complete the frame.
REQ-025 SHALL complete a frame in the stop-sample cycle +1: load data, set rdy, set perr=perr_pend and ferr=ferr_pend, and enter IDLE.
REQ-026 SHALL, at frame completion while rdy is still 1, set ovf and overwrite data.
REQ-027 SHALL, on a cycle where rd is 1 and no frame completes, clear rdy, perr, ferr and ovf on the next edge.
REQ-028 SHALL, when rd and frame completion fall in the same cycle, give completion priority: rdy=1, ovf=0 and the new flags are loaded.
REQ-029 SHALL, when a frame ends with ferr=1 and rxs is still 0 in IDLE, not start a new frame until rxs returns to 1 (a break condition).
REQ-030 SHALL keep the bit-time counter K_W bits wide, clear it on every sample, and never let it wrap.

Reset
REQ-031 SHALL, when rst=1, set the state to IDLE, clear all counters, set data=0, set rdy, perr, ferr, ovf and busy to 0, and set both synchronizer flops to 1.
REQ-032 SHALL, when reset is asserted in the middle of a frame, discard the partial frame; the next start bit is detected normally.

Configuration
REQ-033 SHALL recognise the macro UART_RX_MAJORITY_EN.
REQ-034 SHALL, when UART_RX_MAJORITY_EN is defined, use as each bit value the 2-of-3 majority of rxs at sample points -1, 0 and +1; the START false-start check also uses the majority.
REQ-035 SHALL, when UART_RX_MAJORITY_EN is not defined, use the single rxs value at the sample point; timing of rdy is the same in both builds.

Verification
REQ-036 SHALL cover: k=16, 8N1, byte 0xA5 -> data=0xA5, rdy=1, perr=0, ferr=0, ovf=0, with rdy rising 1 clock after the stop sample.
REQ-037 SHALL cover: k=16, 7 data bits with even parity, 0x55 sent with a wrong parity bit -> data=0x55, perr=1; a following rd clears rdy and perr.
REQ-038 SHALL cover: k=16, 8N2, 0x3C sent with the second stop bit 0 -> data=0x3C, ferr=1.
REQ-039 SHALL cover: a 5-clock low glitch on rx with k=16 -> no rdy, busy returns to 0 and the state is IDLE.
REQ-040 SHALL cover: two frames 0x11 then 0x22 with no rd between them -> data=0x22, ovf=1; rd in the completion cycle of the second frame instead -> ovf=0, rdy=1.
REQ-041 SHALL cover: rst asserted at mid-data of 0xF0, then 0x0F sent -> data=0x0F with no error flags.
